// File: rtl/spi_command_controller_if.sv
// -----------------------------------------------------------------------------
// spi_command_controller_if
// Bundles the SPI pins and the register-side handshake of the SPI command
// controller so they can be passed around as a single port.
//
// Signals:
//   sck, sdi, cs   SPI inputs, already synchronized to clk (cs active-low)
//   sdo            serial read data, MSB-first
//   cmd            last captured command byte
//   wr_strobe      one-cycle pulse, write payload complete
//   wr_data        received write payload
//   rd_req         one-cycle pulse requesting read data for cmd[6:0]
//   rd_data        read data, valid the cycle after rd_req
//   busy           frame in progress
//   abort          one-cycle pulse on a truncated frame
//
// Modports:
//   slave   controller side
//   master  SPI host / register-file side
// -----------------------------------------------------------------------------
interface spi_command_controller_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  sck;
    logic                  sdi;
    logic                  cs;
    logic                  sdo;
    logic [7:0]            cmd;
    logic                  wr_strobe;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  rd_req;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  abort;

    modport slave (
        input  sck, sdi, cs, rd_data,
        output sdo, cmd, wr_strobe, wr_data, rd_req, busy, abort
    );

    modport master (
        output sck, sdi, cs, rd_data,
        input  sdo, cmd, wr_strobe, wr_data, rd_req, busy, abort
    );
endinterface

// File: rtl/spi_command_controller.sv
// -----------------------------------------------------------------------------
// spi_command_controller
// SPI slave that receives an 8-bit command followed by a WORD_WIDTH payload.
// cmd[7]=1 is a write: the payload is shifted in from sdi and presented on
// wr_data with a wr_strobe pulse. cmd[7]=0 is a read: rd_req is pulsed,
// rd_data is latched the following cycle and shifted out on sdo MSB-first.
// A frame ended early by cs rising pulses abort instead of completing.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    spi_command_controller_if.slave (SPI pins + register handshake)
// -----------------------------------------------------------------------------
module spi_command_controller #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_command_controller_if.slave       bus
);
    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        DISPATCH,
        DATA_IN,
        DATA_OUT,
        DONE
    } state_t;

    localparam logic [5:0] CMD_LAST    = 6'd7;
    localparam logic [5:0] SHIFT_FIRST = 6'd9;
    localparam logic [5:0] WORD_LAST   = 6'(7 + WORD_WIDTH);

    state_t                state;
    logic                  sck_prev;
    logic [5:0]            bit_count;
    logic [6:0]            cmd_shift;
    logic [7:0]            cmd_reg;
    logic [WORD_WIDTH-2:0] in_shift;
    logic [WORD_WIDTH-1:0] wr_data_reg;
    logic [WORD_WIDTH-1:0] out_shift;
    logic                  out_load;
    logic                  wr_strobe_reg;
    logic                  rd_req_reg;
    logic                  abort_reg;

    logic                  sck_rise;
    logic                  sck_fall;
    logic [7:0]            cmd_next;
    logic [WORD_WIDTH-1:0] in_next;

    assign sck_rise = bus.sck & ~sck_prev;
    assign sck_fall = ~bus.sck & sck_prev;
    assign cmd_next = {cmd_shift, bus.sdi};
    assign in_next  = {in_shift, bus.sdi};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            sck_prev      <= 1'b1;  // sck held high across reset release is not a rising edge
            bit_count     <= '0;
            cmd_shift     <= '0;
            cmd_reg       <= '0;
            in_shift      <= '0;
            wr_data_reg   <= '0;
            out_shift     <= '0;
            out_load      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            rd_req_reg    <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            sck_prev      <= bus.sck;
            wr_strobe_reg <= 1'b0;
            rd_req_reg    <= 1'b0;
            abort_reg     <= 1'b0;

            // cs deassertion wins over any same-cycle sck edge or completion
            if (state != IDLE && bus.cs) begin
                state    <= IDLE;
                out_load <= 1'b0;
                if (state != DONE && bit_count != '0)
                    abort_reg <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.cs) begin
                            state     <= COMMAND;
                            bit_count <= '0;
                        end
                    end
                    COMMAND: begin
                        if (sck_rise) begin
                            cmd_shift <= cmd_next[6:0];
                            bit_count <= bit_count + 6'd1;
                            if (bit_count == CMD_LAST) begin
                                cmd_reg    <= cmd_next;
                                state      <= DISPATCH;
                                // registered so the pulse lines up with the DISPATCH cycle
                                rd_req_reg <= ~cmd_next[7];
                            end
                        end
                    end
                    DISPATCH: begin
                        if (cmd_reg[7]) begin
                            state <= DATA_IN;
                        end else begin
                            state    <= DATA_OUT;
                            out_load <= 1'b1;
                        end
                    end
                    DATA_IN: begin
                        if (sck_rise) begin
                            in_shift  <= in_next[WORD_WIDTH-2:0];
                            bit_count <= bit_count + 6'd1;
                            if (bit_count == WORD_LAST) begin
                                wr_data_reg   <= in_next;
                                wr_strobe_reg <= 1'b1;
                                state         <= DONE;
                            end
                        end
                    end
                    DATA_OUT: begin
                        if (out_load) begin
                            out_shift <= bus.rd_data;
                            out_load  <= 1'b0;
                        end else if (sck_fall && bit_count >= SHIFT_FIRST
                                     && bit_count <= WORD_LAST) begin
                            // the fall after bit 8 leaves the MSB in place for bit 9
                            out_shift <= {out_shift[WORD_WIDTH-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_count <= bit_count + 6'd1;
                            if (bit_count == WORD_LAST)
                                state <= DONE;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sdo       = (state == DATA_OUT && !out_load) ? out_shift[WORD_WIDTH-1] : 1'b0;
    assign bus.cmd       = cmd_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.wr_strobe = wr_strobe_reg;
    assign bus.rd_req    = rd_req_reg;
    assign bus.abort     = abort_reg;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_command_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_command_controller
// Scoreboard bench for spi_command_controller. Each frame's expected events
// (write strobe, read request, abort) are derived from the frame's command,
// bit count and payload and queued; a monitor pops and compares them as the
// DUT produces them, and also serves rd_data in response to rd_req.
// -----------------------------------------------------------------------------
module tb_spi_command_controller;
    localparam int W = 32;

    typedef enum int {EV_WR, EV_RD, EV_ABORT} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        logic [7:0]   c;
        logic [W-1:0] d;
    } ev_t;

    logic clk;
    logic rst_n;
    ev_t  exp_q[$];
    int   n_checks;
    int   n_pass;

    spi_command_controller_if #(.WORD_WIDTH(W)) bus ();

    spi_command_controller #(.WORD_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected events of one frame, from the frame's length and direction.
    task automatic model_frame(input logic [7:0] c, input logic [W-1:0] payload,
                               input int nbits, input logic [W-1:0] rdval);
        ev_t e;
        if (nbits >= 8 && !c[7]) begin
            e.kind = EV_RD; e.c = c; e.d = rdval;
            exp_q.push_back(e);
        end
        if (nbits >= 1 && nbits < 8 + W) begin
            e.kind = EV_ABORT; e.c = c; e.d = '0;
            exp_q.push_back(e);
        end else if (nbits >= 8 + W && c[7]) begin
            e.kind = EV_WR; e.c = c; e.d = payload;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] c, input logic [W-1:0] payload, input int i);
        if (i < 8) return c[7 - i];
        if (i < 8 + W) return payload[W + 7 - i];
        return logic'($urandom_range(0, 1));
    endfunction

    // One sck period; sdo is sampled just before the rising edge.
    task automatic drive_bit(input logic b, input bit fall, output logic s);
        bus.sdi = b;
        clk_wait(4);
        s = bus.sdo;
        bus.sck = 1'b1;
        clk_wait(4);
        if (fall) bus.sck = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [W-1:0] payload,
                             input int nbits, input logic [W-1:0] rdval, input int gap);
        logic [W-1:0] sdo_word;
        logic s;
        sdo_word = '0;
        model_frame(c, payload, nbits, rdval);
        bus.cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            drive_bit(frame_bit(c, payload, i), 1'b1, s);
            if (i >= 8 && i < 8 + W) sdo_word = {sdo_word[W-2:0], s};
        end
        clk_wait(4);
        bus.cs = 1'b1;
        if (!c[7] && nbits >= 8 + W)
            check($sformatf("sdo_word_cmd%02h", c), 64'(sdo_word), 64'(rdval));
        if (gap >= 2) begin
            clk_wait(2);
            check("idle_after_frame_busy_sdo", {62'd0, bus.busy, bus.sdo}, 64'd0);
            clk_wait(gap - 2);
        end else begin
            clk_wait(gap);
        end
    endtask

    task automatic pop_and_check(input ev_kind_t kind, output ev_t e);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d with empty queue, required no event", kind);
            e.kind = kind; e.c = '0; e.d = '0;
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind) n_pass++;
            else $display("FAIL event_kind: got %0d, required %0d", kind, e.kind);
        end
    endtask

    // Monitor: compares every DUT output event with the head of the queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rd_req) begin
                    pop_and_check(EV_RD, e);
                    check("rd_req_cmd", 64'(bus.cmd), 64'(e.c));
                    bus.rd_data = e.d;
                    @(posedge clk);
                    @(posedge clk);
                    #1 bus.rd_data = W'($urandom);
                end
                if (bus.wr_strobe) begin
                    pop_and_check(EV_WR, e);
                    check("wr_cmd", 64'(bus.cmd), 64'(e.c));
                    check("wr_data", 64'(bus.wr_data), 64'(e.d));
                end
                if (bus.abort) pop_and_check(EV_ABORT, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0]   c;
        logic [W-1:0] p;
        logic         s;
        int           r;
        int           nb;
        n_checks = 0;
        n_pass   = 0;
        rst_n       = 1'b0;
        bus.sck     = 1'b0;
        bus.sdi     = 1'b0;
        bus.cs      = 1'b1;
        bus.rd_data = W'($urandom);
        clk_wait(3);
        check("reset_outputs",
              {19'd0, bus.cmd, bus.wr_data, bus.sdo, bus.busy, bus.wr_strobe, bus.rd_req, bus.abort},
              64'd0);
        rst_n = 1'b1;
        clk_wait(3);

        // Directed frames: write, read, truncation, over-clocking, back-to-back.
        run_frame(8'h85, 32'hDEADBEEF, 40, '0, 3);
        check("write_cmd_hold", 64'(bus.cmd), 64'h85);
        run_frame(8'h12, '0, 40, 32'hA5A50F0F, 3);
        run_frame(8'hC3, 32'h12345678, 20, '0, 3);
        check("truncated_wr_data_hold", 64'(bus.wr_data), 64'hDEADBEEF);
        run_frame(8'h9A, 32'hCAFEF00D, 48, '0, 3);
        run_frame(8'h00, '0, 0, '0, 3);
        run_frame(8'h40, '0, 5, '0, 3);
        run_frame(8'hF0, 32'h0BADC0DE, 40, '0, 1);
        run_frame(8'h55, '0, 40, 32'h8000_0001, 1);
        run_frame(8'hAA, 32'h76543210, 40, '0, 3);

        // Reset in the middle of a read frame with sck high at bit 15.
        c = 8'h3C;
        model_frame(c, '0, 15, 32'h1357_9BDF);
        exp_q.pop_back();  // frame is killed by reset, not by cs: no abort expected
        bus.cs = 1'b0;
        for (int i = 0; i < 15; i++) drive_bit(frame_bit(c, '0, i), (i < 14), s);
        rst_n  = 1'b0;
        bus.cs = 1'b1;
        clk_wait(3);
        check("midframe_reset_outputs",
              {19'd0, bus.cmd, bus.wr_data, bus.sdo, bus.busy, bus.wr_strobe, bus.rd_req, bus.abort},
              64'd0);
        rst_n = 1'b1;
        clk_wait(4);
        check("post_reset_busy", 64'(bus.busy), 64'd0);
        bus.sck = 1'b0;
        clk_wait(4);
        run_frame(8'h81, 32'h0000_0001, 40, '0, 3);
        check("post_reset_wr_data", 64'(bus.wr_data), 64'd1);

        // Randomized frames.
        for (int k = 0; k < 16; k++) begin
            c = {1'($urandom_range(0, 1)), 7'($urandom)};
            p = W'($urandom);
            r = $urandom_range(0, 5);
            case (r)
                0:       nb = $urandom_range(0, 7);
                1:       nb = $urandom_range(8, 39);
                4:       nb = $urandom_range(41, 48);
                5:       nb = 8;
                default: nb = 40;
            endcase
            run_frame(c, p, nb, W'($urandom), $urandom_range(1, 4));
        end

        clk_wait(6);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
